// File: rtl/up_counter.sv
// rtl/up_counter.sv - free-running binary up-counter with terminal-count and wrap pulse (optional UP_COUNTER_SATURATE_EN)
module up_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;

    assign at_max = (count_q == COUNT_MAX);

    // Next-state: advance by one; at all-ones either hold (saturating) or roll to zero and flag the wrap.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = 1'b0;
`ifdef UP_COUNTER_SATURATE_EN
        if (at_max) begin
            count_d = count_q;
        end
`else
        wrap_d  = at_max;
`endif
    end

    // State register; reset wins over increment and never produces a wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = at_max;

endmodule

// File: tb/tb_up_counter.sv
// tb/tb_up_counter.sv - directed self-checking bench for up_counter at WIDTH=6 and WIDTH=3
module tb_up_counter;

`ifdef UP_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] count6;
    logic       tc6;
    logic       wrap6;
    logic [2:0] count3;
    logic       tc3;
    logic       wrap3;

    int tests_run;
    int tests_failed;

    up_counter #(.WIDTH(6)) u_cnt6 (
        .clk   (clk),
        .rst   (rst),
        .count (count6),
        .tc    (tc6),
        .wrap  (wrap6)
    );

    up_counter #(.WIDTH(3)) u_cnt3 (
        .clk   (clk),
        .rst   (rst),
        .count (count3),
        .tc    (tc3),
        .wrap  (wrap3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected count after n non-reset edges since reset release, for a counter whose top value is max.
    function automatic logic [31:0] exp_cnt(input int n, input int max);
        if (SAT) return (n > max) ? max : n;
        return n % (max + 1);
    endfunction

    function automatic logic [31:0] exp_wrap(input int n, input int max);
        if (SAT) return 0;
        return (n > 0 && (n % (max + 1)) == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input int n);
        chk({tag, " count6"}, count6, exp_cnt(n, 63));
        chk({tag, " tc6"},    tc6,    (exp_cnt(n, 63) == 63) ? 1 : 0);
        chk({tag, " wrap6"},  wrap6,  exp_wrap(n, 63));
        chk({tag, " count3"}, count3, exp_cnt(n, 7));
        chk({tag, " tc3"},    tc3,    (exp_cnt(n, 7) == 7) ? 1 : 0);
        chk({tag, " wrap3"},  wrap3,  exp_wrap(n, 7));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;

        // single reset edge
        tick(1'b1);
        chk_all("reset1", 0);
        // reset held for three more edges
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk_all("reset3", 0);

        // release: 70 edges covers the full 0..63 period, the wrap and saturation hold
        for (int n = 1; n <= 70; n++) begin
            tick(1'b0);
            chk_all($sformatf("run n=%0d", n), n);
        end

        // reset mid-count at 37
        tick(1'b1);
        chk_all("rst_a", 0);
        for (int i = 0; i < 37; i++) tick(1'b0);
        chk("at37 count6", count6, 37);
        chk("at37 tc6", tc6, 0);
        tick(1'b1);
        chk_all("rst_at37", 0);

        // reset while all-ones: no wrap pulse
        for (int i = 0; i < 63; i++) tick(1'b0);
        chk("at63 count6", count6, 63);
        chk("at63 tc6", tc6, 1);
        tick(1'b1);
        chk_all("rst_at63", 0);

        // release again: first edge gives 1
        tick(1'b0);
        chk_all("rerun", 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
